// File: rtl/pacman_pkg.sv
// pacman_pkg: types and constants shared by the Pac-Man motion stage and the
// mouth-animation FSM.
//   dir_t          heading / wall-bit index: 00 up, 01 down, 10 left, 11 right
//   motion_state_t motion FSM state
//   KEY_W/S/A/D    USB HID keycodes for WASD
//   opposite()     reverse heading
package pacman_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_MOVE    = 2'b01,
    ST_BLOCKED = 2'b10
  } motion_state_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;

  // Encoding pairs opposites on bit 0 (up/down, left/right).
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/pacman_motion_if.sv
// pacman_motion_if: game-side bundle of the motion stage.
//   master (game/testbench): drives playon, keycode, wall; reads position.
//   slave  (pacman_motion):  reads inputs, drives tile_x/y, pac_x/y, dir,
//                            moving, step_pulse.
interface pacman_motion_if;
  import pacman_pkg::*;

  logic       playon;
  logic [7:0] keycode;
  logic [3:0] wall;
  logic [4:0] tile_x;
  logic [4:0] tile_y;
  logic [9:0] pac_x;
  logic [9:0] pac_y;
  dir_t       dir;
  logic       moving;
  logic       step_pulse;

  modport master (
    output playon, keycode, wall,
    input  tile_x, tile_y, pac_x, pac_y, dir, moving, step_pulse
  );

  modport slave (
    input  playon, keycode, wall,
    output tile_x, tile_y, pac_x, pac_y, dir, moving, step_pulse
  );

endinterface

// File: rtl/pacman_key_decode.sv
// pacman_key_decode: WASD keycode -> heading. Purely combinational.
//   keycode_i    USB keycode
//   key_valid_o  1 when keycode is one of W/A/S/D
//   key_dir_o    decoded heading (don't-care when not valid)
module pacman_key_decode
  import pacman_pkg::*;
(
  input  logic [7:0] keycode_i,
  output logic       key_valid_o,
  output dir_t       key_dir_o
);

  always_comb begin
    key_valid_o = 1'b1;
    key_dir_o   = DIR_LEFT;
    case (keycode_i)
      KEY_W:   key_dir_o = DIR_UP;
      KEY_S:   key_dir_o = DIR_DOWN;
      KEY_A:   key_dir_o = DIR_LEFT;
      KEY_D:   key_dir_o = DIR_RIGHT;
      default: key_valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pacman_motion.sv
// pacman_motion: tile-aligned Pac-Man motion, one update per video frame.
// Buffers the last WASD direction, applies it at tile centres (reversal at
// any step), stops on walls and steps 1 px every STEP_DIV frames.
//   frame_clk  frame-rate clock
//   Reset      async, active-high
//   mif        pacman_motion_if.slave (playon/keycode/wall in, position out)
// Build option: define TUNNEL_WRAP_EN to wrap x between X_ORIGIN and X_MAX
// on a horizontal step off the maze edge; otherwise that step blocks.
module pacman_motion
  import pacman_pkg::*;
#(
  parameter int unsigned TILE_LOG2 = 3,
  parameter logic [9:0]  X_ORIGIN  = 10'd0,
  parameter logic [9:0]  Y_ORIGIN  = 10'd0,
  parameter logic [9:0]  START_X   = 10'd112,
  parameter logic [9:0]  START_Y   = 10'd184,
  parameter logic [9:0]  X_MAX     = 10'd223,
  parameter int unsigned STEP_DIV  = 2
) (
  input logic             frame_clk,
  input logic             Reset,
  pacman_motion_if.slave  mif
);

  localparam int unsigned DIV_W     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [9:0]  TILE_MASK = 10'((1 << TILE_LOG2) - 1);
  localparam logic [9:0]  TILE_HALF = 10'(1 << (TILE_LOG2 - 1));

  motion_state_t    state_q, state_d;
  dir_t             dir_q, dir_d;
  dir_t             req_dir_q, req_dir_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       pac_x_q, pac_x_d;
  logic [9:0]       pac_y_q, pac_y_d;
  logic             step_q, step_d;

  logic             key_valid;
  dir_t             key_dir;

  pacman_key_decode u_key (
    .keycode_i   (mif.keycode),
    .key_valid_o (key_valid),
    .key_dir_o   (key_dir)
  );

  logic [9:0] rel_x, rel_y;
  logic       centred, step_frame, turn, step_ok;
  dir_t       move_dir;
  logic [9:0] nx, ny;

  assign rel_x      = pac_x_q - X_ORIGIN;
  assign rel_y      = pac_y_q - Y_ORIGIN;
  assign centred    = ((rel_x & TILE_MASK) == TILE_HALF) &&
                      ((rel_y & TILE_MASK) == TILE_HALF);
  assign step_frame = (div_cnt_q == DIV_W'(STEP_DIV - 1));

  // Reversal never needs the centre or a wall check: the tile behind is open.
  assign turn     = (req_dir_q != dir_q) &&
                    ((centred && !mif.wall[req_dir_q]) ||
                     (req_dir_q == opposite(dir_q)));
  assign move_dir = turn ? req_dir_q : dir_q;

  // Candidate 1-px step in move_dir; step_ok drops when the step would leave
  // the maze horizontally and tunnel wrap is not built in.
  always_comb begin
    nx      = pac_x_q;
    ny      = pac_y_q;
    step_ok = 1'b1;
    case (move_dir)
      DIR_UP:   ny = pac_y_q - 10'd1;
      DIR_DOWN: ny = pac_y_q + 10'd1;
      DIR_LEFT: begin
        if (pac_x_q == X_ORIGIN) begin
`ifdef TUNNEL_WRAP_EN
          nx = X_MAX;
`else
          step_ok = 1'b0;
`endif
        end else begin
          nx = pac_x_q - 10'd1;
        end
      end
      default: begin
        if (pac_x_q == X_MAX) begin
`ifdef TUNNEL_WRAP_EN
          nx = X_ORIGIN;
`else
          step_ok = 1'b0;
`endif
        end else begin
          nx = pac_x_q + 10'd1;
        end
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    req_dir_d = key_valid ? key_dir : req_dir_q;
    div_cnt_d = div_cnt_q;
    pac_x_d   = pac_x_q;
    pac_y_d   = pac_y_q;
    step_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_valid) begin
          dir_d     = key_dir;
          div_cnt_d = '0;
          state_d   = mif.wall[key_dir] ? ST_BLOCKED : ST_MOVE;
        end
      end
      ST_MOVE: begin
        if (step_frame) begin
          div_cnt_d = '0;
          if (!turn && centred && mif.wall[dir_q]) begin
            state_d = ST_BLOCKED;
          end else begin
            dir_d = move_dir;
            if (step_ok) begin
              pac_x_d = nx;
              pac_y_d = ny;
              step_d  = 1'b1;
            end else begin
              state_d = ST_BLOCKED;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      ST_BLOCKED: begin
        div_cnt_d = '0;
        if (!mif.wall[req_dir_q]) begin
          dir_d   = req_dir_q;
          state_d = ST_MOVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // playon low is a synchronous restart with the same values as Reset.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_LEFT;
      req_dir_q <= DIR_LEFT;
      div_cnt_q <= '0;
      pac_x_q   <= START_X;
      pac_y_q   <= START_Y;
      step_q    <= 1'b0;
    end else if (!mif.playon) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_LEFT;
      req_dir_q <= DIR_LEFT;
      div_cnt_q <= '0;
      pac_x_q   <= START_X;
      pac_y_q   <= START_Y;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      req_dir_q <= req_dir_d;
      div_cnt_q <= div_cnt_d;
      pac_x_q   <= pac_x_d;
      pac_y_q   <= pac_y_d;
      step_q    <= step_d;
    end
  end

  assign mif.tile_x     = 5'(rel_x >> TILE_LOG2);
  assign mif.tile_y     = 5'(rel_y >> TILE_LOG2);
  assign mif.pac_x      = pac_x_q;
  assign mif.pac_y      = pac_y_q;
  assign mif.dir        = dir_q;
  assign mif.moving     = (state_q == ST_MOVE);
  assign mif.step_pulse = step_q;

endmodule

// File: tb/tb_pacman_motion.sv
// tb_pacman_motion: directed scenarios for pacman_motion. Every expected pixel
// step is queued by the stimulus; a monitor pops one per step_pulse frame.
// Start y is 188 (tile-centred row) so horizontal runs pass tile centres.
module tb_pacman_motion;
  import pacman_pkg::*;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    dir_t       d;
  } step_t;

  logic  frame_clk = 1'b0;
  logic  Reset;
  int    vectors = 0;
  int    errors  = 0;
  step_t exp_q[$];

  pacman_motion_if mif();

  pacman_motion #(.START_Y(10'd188)) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .mif       (mif)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic frames(input int n);
    repeat (n) @(negedge frame_clk);
    #1;
  endtask

  task automatic push(input int x, input int y, input dir_t d);
    step_t s;
    s.x = 10'(x);
    s.y = 10'(y);
    s.d = d;
    exp_q.push_back(s);
  endtask

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  initial begin : main
    Reset       = 1'b1;
    mif.playon  = 1'b0;
    mif.keycode = 8'h00;
    mif.wall    = 4'b0000;

    fork
      forever begin
        step_t e;
        @(negedge frame_clk);
        if (!Reset && mif.step_pulse === 1'b1) begin
          vectors++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_step: got x=%0d y=%0d dir=%0d, required no step",
                     mif.pac_x, mif.pac_y, mif.dir);
          end else begin
            e = exp_q.pop_front();
            if (mif.pac_x !== e.x || mif.pac_y !== e.y || mif.dir !== e.d) begin
              errors++;
              $display("FAIL step: got x=%0d y=%0d dir=%0d, required x=%0d y=%0d dir=%0d",
                       mif.pac_x, mif.pac_y, mif.dir, e.x, e.y, e.d);
            end
          end
        end
      end
    join_none

    // Reset state, held by playon low.
    frames(2);
    Reset = 1'b0;
    frames(1);
    chk("rst_x", int'(mif.pac_x), 112);
    chk("rst_y", int'(mif.pac_y), 188);
    chk("rst_dir", int'(mif.dir), int'(DIR_LEFT));
    chk("rst_moving", int'(mif.moving), 0);
    chk("rst_step", int'(mif.step_pulse), 0);
    chk("rst_tile_x", int'(mif.tile_x), 14);
    chk("rst_tile_y", int'(mif.tile_y), 23);

    // Start left, 1 px every 2nd frame.
    mif.playon  = 1'b1;
    mif.keycode = KEY_A;
    push(111, 188, DIR_LEFT);
    push(110, 188, DIR_LEFT);
    frames(1);
    chk("start_moving", int'(mif.moving), 1);
    chk("start_no_step", int'(mif.step_pulse), 0);
    frames(4);

    // Buffered up-turn taken at the x=108 tile centre.
    mif.keycode = KEY_W;
    push(109, 188, DIR_LEFT);
    push(108, 188, DIR_LEFT);
    push(108, 187, DIR_UP);
    push(108, 186, DIR_UP);
    frames(8);
    chk("turn_dir", int'(mif.dir), int'(DIR_UP));
    chk("turn_tile_x", int'(mif.tile_x), 13);
    chk("turn_tile_y", int'(mif.tile_y), 23);
    chk("turn_q_empty", exp_q.size(), 0);

    // playon dropped mid-move restarts on the next edge.
    frames(1);
    mif.playon = 1'b0;
    frames(1);
    chk("playon_x", int'(mif.pac_x), 112);
    chk("playon_y", int'(mif.pac_y), 188);
    chk("playon_dir", int'(mif.dir), int'(DIR_LEFT));
    chk("playon_moving", int'(mif.moving), 0);

    // Wall ahead at a centre blocks; a right key with that side open resumes.
    mif.playon  = 1'b1;
    mif.keycode = KEY_A;
    push(111, 188, DIR_LEFT);
    push(110, 188, DIR_LEFT);
    push(109, 188, DIR_LEFT);
    push(108, 188, DIR_LEFT);
    frames(9);
    mif.wall = 4'b0100;
    frames(2);
    chk("blk_moving", int'(mif.moving), 0);
    chk("blk_x", int'(mif.pac_x), 108);
    chk("blk_q_empty", exp_q.size(), 0);
    frames(1);
    chk("blk_hold_moving", int'(mif.moving), 0);
    mif.keycode = KEY_D;
    frames(2);
    chk("unblk_moving", int'(mif.moving), 1);
    chk("unblk_dir", int'(mif.dir), int'(DIR_RIGHT));
    push(109, 188, DIR_RIGHT);
    frames(2);

    // Mid-tile reversal, then the left wall blocks again at the centre.
    mif.keycode = KEY_A;
    push(108, 188, DIR_LEFT);
    frames(4);
    chk("rev_moving", int'(mif.moving), 0);
    chk("rev_dir", int'(mif.dir), int'(DIR_LEFT));
    chk("rev_x", int'(mif.pac_x), 108);
    chk("rev_q_empty", exp_q.size(), 0);

    // Run left to the maze edge.
    mif.playon = 1'b0;
    mif.wall   = 4'b0000;
    frames(1);
    mif.playon = 1'b1;
    for (int x = 111; x >= 0; x--) push(x, 188, DIR_LEFT);
`ifdef TUNNEL_WRAP_EN
    push(223, 188, DIR_LEFT);
`endif
    frames(227);
`ifdef TUNNEL_WRAP_EN
    chk("edge_x", int'(mif.pac_x), 223);
    chk("edge_moving", int'(mif.moving), 1);
    chk("edge_tile_x", int'(mif.tile_x), 27);
`else
    chk("edge_x", int'(mif.pac_x), 0);
    chk("edge_moving", int'(mif.moving), 0);
    chk("edge_tile_x", int'(mif.tile_x), 0);
`endif
    chk("edge_q_empty", exp_q.size(), 0);

    // Asynchronous Reset between clock edges.
    #2;
    Reset = 1'b1;
    #1;
    chk("areset_x", int'(mif.pac_x), 112);
    chk("areset_y", int'(mif.pac_y), 188);
    chk("areset_dir", int'(mif.dir), int'(DIR_LEFT));
    chk("areset_moving", int'(mif.moving), 0);
    chk("areset_step", int'(mif.step_pulse), 0);
    frames(1);
    Reset = 1'b0;
    frames(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
